// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM state codes, handshake
// levels and the EX-stage opcodes that steer operations into it.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Produces {remainder, quotient}; remainder carries the dividend's sign.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     quot_fix;
  logic [DATA_W-1:0]     rem_fix;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    // Trial subtraction of the divisor from the upper half of the work register
    diff     = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    quot_fix = neg_quot_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    rem_fix  = neg_rem_q ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];

    unique case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          divisor_d  = magnitude(opdata2_i, signed_div_i);
          neg_quot_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d  = signed_div_i & opdata1_i[DATA_W-1];
          work_d     = {{DATA_W{1'b0}}, magnitude(opdata1_i, signed_div_i), 1'b0};
          cnt_d      = '0;
          state_d    = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_d = DIV_FREE;
        end else begin
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul_i || start_i == DIV_STOP) begin
          state_d = DIV_FREE;
        end else if (cnt_q != LAST_STEP) begin
          if (diff[DATA_W]) begin
            work_d = {work_q[2*DATA_W-1:0], 1'b0};
          end else begin
            work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end
      DIV_END: begin
        // EX keeps start high until it has consumed the result
        if (start_i == DIV_STOP) begin
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
          state_d  = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random stimulus for div_unit; expected results are queued
// when an operation is launched and checked when ready_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        sdiv;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (sdiv),
    .opdata1_i    (a),
    .opdata2_i    (b),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %h, need %h", tag, obs, expv);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d, need %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    if (y == 32'd0) return 64'd0;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
    end else begin
      sx = {32'd0, x};
      sy = {32'd0, y};
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic launch(input bit s, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    sdiv  = s;
    a     = x;
    b     = y;
    start = 1'b1;
    annul = 1'b0;
  endtask

  task automatic push_exp(input bit s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.res = model(s, x, y);
    e.lat = (y == 32'd0) ? 1 : 33;
    sb.push_back(e);
  endtask

  // Waits from the accepting edge E0 until ready_o, then optionally releases start.
  task automatic collect(input string tag, input bit drop);
    exp_t e;
    int   n;
    @(posedge clk);
    #1;
    a    = $urandom;
    b    = $urandom;
    sdiv = ~sdiv;
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready) break;
    end
    e = sb.pop_front();
    chkint({tag, " latency"}, n, e.lat);
    if (ready) chk64({tag, " result"}, result, e.res);
    if (drop) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      chkint({tag, " ready_drop"}, int'(ready), 0);
      chk64({tag, " result_clr"}, result, 64'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, need $finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    annul = 1'b0;
    sdiv  = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chkint("reset ready", int'(ready), 0);
    chk64("reset result", result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed arithmetic cases
    launch(0, 32'd100, 32'd7);             push_exp(0, 32'd100, 32'd7);             collect("divu_100_7", 1);
    launch(1, -32'sd7, 32'd2);             push_exp(1, -32'sd7, 32'd2);             collect("div_m7_2", 1);
    launch(1, 32'd7, -32'sd2);             push_exp(1, 32'd7, -32'sd2);             collect("div_7_m2", 1);
    launch(1, 32'h8000_0000, 32'hFFFF_FFFF); push_exp(1, 32'h8000_0000, 32'hFFFF_FFFF); collect("div_min_m1", 1);
    launch(1, 32'd5, 32'd0);               push_exp(1, 32'd5, 32'd0);               collect("div_by0", 1);
    launch(0, 32'd5, 32'd0);               push_exp(0, 32'd5, 32'd0);               collect("divu_by0", 1);
    launch(0, 32'hFFFF_FFFF, 32'd2);       push_exp(0, 32'hFFFF_FFFF, 32'd2);       collect("divu_max_2", 1);
    launch(1, 32'hFFFF_FFFF, 32'd2);       push_exp(1, 32'hFFFF_FFFF, 32'd2);       collect("div_m1_2", 1);

    // Abort by annul at step 10, then a fresh 9/3 while start stays high
    launch(0, 32'hFFFF_FFFF, 32'd3);
    @(posedge clk);
    repeat (10) begin
      @(posedge clk);
      #1;
      chkint("annul pre ready", int'(ready), 0);
    end
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    chkint("annul edge ready", int'(ready), 0);
    @(negedge clk);
    annul = 1'b0;
    a     = 32'd9;
    b     = 32'd3;
    sdiv  = 1'b0;
    push_exp(0, 32'd9, 32'd3);
    collect("after_annul", 1);

    // Abort by dropping start at step 20
    launch(0, 32'hFFFF_FFFF, 32'd3);
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chkint("stop edge ready", int'(ready), 0);
    @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd3;
    sdiv  = 1'b0;
    push_exp(0, 32'd9, 32'd3);
    collect("after_stop", 1);

    // Asynchronous reset while a result is held
    launch(0, 32'd100, 32'd7);
    push_exp(0, 32'd100, 32'd7);
    collect("pre_reset", 0);
    #3;
    rst = 1'b0;
    #1;
    chkint("rst_end ready", int'(ready), 0);
    chk64("rst_end result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset mid-division, then a normal op from FREE
    launch(1, 32'd1234567, 32'd89);
    @(posedge clk);
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chkint("rst_on ready", int'(ready), 0);
    chk64("rst_on result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    launch(1, -32'sd1000, 32'd7);          push_exp(1, -32'sd1000, 32'd7);          collect("post_reset", 1);

    // Random operands in both modes
    for (int i = 0; i < 300; i++) begin
      bit          s;
      logic [31:0] x, y;
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      if (i % 4 == 1) y = $urandom_range(1, 255);
      if (i % 8 == 2) y = -$urandom_range(1, 255);
      if (i % 16 == 3) y = 32'd0;
      launch(s, x, y);
      push_exp(s, x, y);
      collect("random", 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
